fft8_seq: RTL and testbench

FFT8_SEQ -- requirements
Module: fft8_seq

---
 rtl/fft8_pkg.sv | 31 +++
 rtl/fft8_addr_gen.sv | 32 +++
 rtl/fft8_seq.sv | 150 +++++++++++++++
 tb/tb_fft8_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT sequencer.
// Holds the FSM state encoding, transform size, counter limits and the
// bit-reverse helper used to scramble load addresses.
package fft8_pkg;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = $clog2(N);

    localparam logic [AW-1:0] LMT_SAMPLES = AW'(N - 1);
    localparam logic [AW-1:0] LMT_BFLY    = AW'(N / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLdSet,
        StLoad,
        StStSet,
        StBfly,
        StOutSet,
        StUnload,
        StDone
    } state_e;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) begin
            r[i] = x[AW-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft8_addr_gen.sv
// Butterfly operand address and twiddle generator (purely combinational).
// Ports:
//   stage     in  2   current radix-2 stage s (0..2)
//   b         in  3   butterfly index within the stage (0..3)
//   bf_addr_a out 3   upper operand address
//   bf_addr_b out 3   lower operand address (bf_addr_a + 2^s)
//   bf_tw     out 2   twiddle exponent k of W8^k
module fft8_addr_gen
    import fft8_pkg::*;
(
    input  logic [1:0]    stage,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] bf_addr_a,
    output logic [AW-1:0] bf_addr_b,
    output logic [1:0]    bf_tw
);

    logic [AW-1:0] h;
    logic [AW-1:0] p;
    logic [AW-1:0] g;

    always_comb begin
        h         = AW'(1) << stage;
        p         = b & (h - AW'(1));
        g         = b >> stage;
        // Group base is g * 2h; OR is safe because p < h never overlaps it.
        bf_addr_a = ((g << stage) << 1) | p;
        bf_addr_b = bf_addr_a + h;
        bf_tw     = 2'(p << (2'd2 - stage));
    end

endmodule

// File: rtl/fft8_seq.sv
// Control sequencer for an in-place radix-2 8-point FFT.
// Drives an external loadable phase counter, scrambles load addresses,
// issues butterflies for three stages and unloads results in natural order.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   start                      begin a transform (sampled in IDLE only)
//   in_valid / out_ready       load / unload handshakes
//   cnt_out, cnt_tc            external counter value and terminal count
//   cnt_load, cnt_en           external counter control
//   cnt_data, cnt_lmt          external counter load value and limit
//   mem_wr, mem_wr_addr        sample RAM write strobe and address
//   bf_valid, bf_addr_a/b      butterfly issue strobe and operand addresses
//   bf_tw, stage               twiddle exponent and current stage
//   out_valid, out_addr        output sample strobe and address
//   busy, done                 not-idle flag, completion pulse
module fft8_seq
    import fft8_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic          out_ready,
    input  logic [AW-1:0] cnt_out,
    input  logic          cnt_tc,
    output logic          cnt_load,
    output logic          cnt_en,
    output logic [AW-1:0] cnt_data,
    output logic [AW-1:0] cnt_lmt,
    output logic          mem_wr,
    output logic [AW-1:0] mem_wr_addr,
    output logic          bf_valid,
    output logic [AW-1:0] bf_addr_a,
    output logic [AW-1:0] bf_addr_b,
    output logic [1:0]    bf_tw,
    output logic [1:0]    stage,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [1:0]    stage_q, stage_d;
    logic [AW-1:0] gen_a, gen_b;
    logic [1:0]    gen_tw;

    fft8_addr_gen u_addr_gen (
        .stage     (stage_q),
        .b         (cnt_out),
        .bf_addr_a (gen_a),
        .bf_addr_b (gen_b),
        .bf_tw     (gen_tw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            stage_q <= 2'd0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_data    = '0;
        cnt_lmt     = '0;
        mem_wr      = 1'b0;
        mem_wr_addr = '0;
        bf_valid    = 1'b0;
        bf_addr_a   = '0;
        bf_addr_b   = '0;
        bf_tw       = 2'd0;
        out_valid   = 1'b0;
        out_addr    = '0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLdSet;
            end
            StLdSet: begin
                cnt_load = 1'b1;
                cnt_lmt  = LMT_SAMPLES;
                state_d  = StLoad;
            end
            StLoad: begin
                cnt_lmt     = LMT_SAMPLES;
                cnt_en      = in_valid;
                mem_wr      = in_valid;
                mem_wr_addr = bitrev(cnt_out);
                if (cnt_tc && in_valid) begin
                    stage_d = 2'd0;
                    state_d = StStSet;
                end
            end
            StStSet: begin
                cnt_load = 1'b1;
                cnt_lmt  = LMT_BFLY;
                state_d  = StBfly;
            end
            StBfly: begin
                cnt_lmt   = LMT_BFLY;
                cnt_en    = 1'b1;
                bf_valid  = 1'b1;
                bf_addr_a = gen_a;
                bf_addr_b = gen_b;
                bf_tw     = gen_tw;
                if (cnt_tc) begin
                    if (stage_q < 2'd2) begin
                        stage_d = stage_q + 2'd1;
                        state_d = StStSet;
                    end else begin
                        state_d = StOutSet;
                    end
                end
            end
            StOutSet: begin
                cnt_load = 1'b1;
                cnt_lmt  = LMT_SAMPLES;
                state_d  = StUnload;
            end
            StUnload: begin
                cnt_lmt   = LMT_SAMPLES;
                cnt_en    = out_ready;
                out_valid = 1'b1;
                out_addr  = cnt_out;
                if (cnt_tc && out_ready) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                stage_d = 2'd0;
                state_d = StIdle;
            end
            default: begin
                stage_d = 2'd0;
                state_d = StIdle;
            end
        endcase
    end

    assign stage = stage_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_fft8_seq.sv
// Directed bench for fft8_seq with a 3-bit loadable phase counter model.
module tb_fft8_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] cnt_out;
    logic       cnt_tc;
    logic       cnt_load, cnt_en;
    logic [2:0] cnt_data, cnt_lmt;
    logic       mem_wr;
    logic [2:0] mem_wr_addr;
    logic       bf_valid;
    logic [2:0] bf_addr_a, bf_addr_b;
    logic [1:0] bf_tw, stage;
    logic       out_valid;
    logic [2:0] out_addr;
    logic       busy, done;

    always #5 clk = ~clk;

    fft8_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .cnt_out     (cnt_out),
        .cnt_tc      (cnt_tc),
        .cnt_load    (cnt_load),
        .cnt_en      (cnt_en),
        .cnt_data    (cnt_data),
        .cnt_lmt     (cnt_lmt),
        .mem_wr      (mem_wr),
        .mem_wr_addr (mem_wr_addr),
        .bf_valid    (bf_valid),
        .bf_addr_a   (bf_addr_a),
        .bf_addr_b   (bf_addr_b),
        .bf_tw       (bf_tw),
        .stage       (stage),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .busy        (busy),
        .done        (done)
    );

    // 3-bit loadable counter with terminal count against the limit.
    logic [2:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cnt_q <= 3'd0;
        else if (cnt_load) cnt_q <= cnt_data;
        else if (cnt_en)   cnt_q <= cnt_q + 3'd1;
    end
    assign cnt_out = cnt_q;
    assign cnt_tc  = (cnt_q == cnt_lmt);

    typedef struct {
        logic [1:0] s;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
    } bf_t;

    typedef struct {
        int in_lo;
        int in_hi;
        int out_lo;
        int out_hi;
        bit hold;
        int exp_done;
    } sc_t;

    bf_t        bf_tab[12];
    logic [2:0] wr_tab[8];
    sc_t        sc_tab[4];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {3'b0, cnt_load, cnt_en, cnt_data, cnt_lmt, mem_wr, mem_wr_addr, bf_valid,
                bf_addr_a, bf_addr_b, bf_tw, stage, out_valid, out_addr, busy, done};
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        #1 check("reset_outputs_zero", all_outs(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one transform; cycle 1 is the LD_SET cycle after start is sampled.
    task automatic run_sc(input int idx);
        sc_t sc;
        int  c, nw, nb, no, done_c, ndone;
        sc     = sc_tab[idx];
        nw     = 0;
        nb     = 0;
        no     = 0;
        done_c = -1;
        ndone  = 0;
        start  = 1'b1;
        @(posedge clk);
        c = 1;
        while (c <= 80 && done_c < 0) begin
            #1;
            if (!sc.hold) start = 1'b0;
            in_valid  = !(c >= sc.in_lo && c <= sc.in_hi);
            out_ready = !(c >= sc.out_lo && c <= sc.out_hi);
            @(negedge clk);
            if (mem_wr) begin
                check($sformatf("sc%0d_wr_addr%0d", idx, nw), 32'(mem_wr_addr),
                      (nw < 8) ? 32'(wr_tab[nw]) : 32'hff);
                nw++;
            end
            if (bf_valid) begin
                check($sformatf("sc%0d_bfly%0d", idx, nb), {22'd0, stage, bf_addr_a, bf_addr_b, bf_tw},
                      (nb < 12) ? {22'd0, bf_tab[nb].s, bf_tab[nb].a, bf_tab[nb].b, bf_tab[nb].tw}
                                : 32'hffff);
                nb++;
            end
            if (out_valid) begin
                check($sformatf("sc%0d_out_addr_c%0d", idx, c), 32'(out_addr), 32'(no));
                if (out_ready) no++;
            end
            if (done) begin
                done_c = c;
                ndone++;
            end
            @(posedge clk);
            c++;
        end
        check($sformatf("sc%0d_done_cycle", idx), 32'(done_c), 32'(sc.exp_done));
        check($sformatf("sc%0d_wr_count", idx), 32'(nw), 32'd8);
        check($sformatf("sc%0d_bfly_count", idx), 32'(nb), 32'd12);
        check($sformatf("sc%0d_out_count", idx), 32'(no), 32'd8);
        if (sc.hold && done_c > 0) begin
            // c is now done_c + 1: DONE ignored start, so this is IDLE.
            #1;
            @(negedge clk);
            check("hold_idle_after_done", {30'd0, busy, cnt_load}, 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("hold_restart_ldset", {30'd0, busy, cnt_load}, 32'd3);
            start = 1'b0;
        end
        #1;
    endtask

    initial begin
        bf_tab[0]  = '{2'd0, 3'd0, 3'd1, 2'd0};
        bf_tab[1]  = '{2'd0, 3'd2, 3'd3, 2'd0};
        bf_tab[2]  = '{2'd0, 3'd4, 3'd5, 2'd0};
        bf_tab[3]  = '{2'd0, 3'd6, 3'd7, 2'd0};
        bf_tab[4]  = '{2'd1, 3'd0, 3'd2, 2'd0};
        bf_tab[5]  = '{2'd1, 3'd1, 3'd3, 2'd2};
        bf_tab[6]  = '{2'd1, 3'd4, 3'd6, 2'd0};
        bf_tab[7]  = '{2'd1, 3'd5, 3'd7, 2'd2};
        bf_tab[8]  = '{2'd2, 3'd0, 3'd4, 2'd0};
        bf_tab[9]  = '{2'd2, 3'd1, 3'd5, 2'd1};
        bf_tab[10] = '{2'd2, 3'd2, 3'd6, 2'd2};
        bf_tab[11] = '{2'd2, 3'd3, 3'd7, 2'd3};
        wr_tab[0] = 3'd0; wr_tab[1] = 3'd4; wr_tab[2] = 3'd2; wr_tab[3] = 3'd6;
        wr_tab[4] = 3'd1; wr_tab[5] = 3'd5; wr_tab[6] = 3'd3; wr_tab[7] = 3'd7;
        sc_tab[0] = '{0, -1,  0, -1, 1'b0, 34};   // no stalls
        sc_tab[1] = '{4,  6,  0, -1, 1'b0, 37};   // in_valid low after 2nd sample
        sc_tab[2] = '{0, -1, 31, 32, 1'b0, 36};   // out_ready low at out_addr 5
        sc_tab[3] = '{0, -1,  0, -1, 1'b1, 34};   // start held throughout

        do_reset();
        check("idle_outputs_zero", all_outs(), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_sc(i);
            do_reset();
        end

        // Asynchronous reset in the middle of stage 1.
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);   // now in cycle 16, first stage-1 butterfly
        @(negedge clk);
        check("midrun_in_stage1", {29'd0, bf_valid, stage}, {29'd0, 1'b1, 2'd1});
        #2 rst = 1'b0;
        #1 check("midrun_async_reset", all_outs(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_sc(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
